msx_reload_seq: RTL and testbench
=================================

Name: msx_reload_seq

Overview:
- Sequences an MSX cold restart whenever the cartridge configuration changes or a cartridge ROM finishes downloading.
- Sits between the config decoder's reload pulse, the HPS ioctl download stream and the SDRAM clear engine. Holds the MSX core in reset, clears mapper/SRAM regions of retyped slots, waits out active downloads, then releases the core and publishes per-slot enables.

Parameters:
- HOLD_CYCLES, 1024: minimum cycles msx_reset is held before any other step; range 1..65535.
- CLR_TIMEOUT, 1048576: maximum cycles to wait for clr_ack before abandoning a clear; 21-bit counter.
- ROM_A_INDEX, 8'd1: ioctl_index of the slot A cartridge ROM download.
- ROM_B_INDEX, 8'd2: ioctl_index of the slot B cartridge ROM download.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- reload  in  1  one-cycle pulse, cartridge type changed
- cart_typ  in  2x3  current cart_typ_t of slot A [0] / slot B [1]
- ioctl_download  in  1  HPS download active
- ioctl_index  in  8  index of current download
- clr_req  out  1  SDRAM clear request, level, held until ack or timeout
- clr_slot  out  1  slot whose region is cleared (0=A, 1=B)
- clr_ack  in  1  one-cycle clear completion
- msx_reset  out  1  active-high reset to MSX core
- slot_en  out  2  per-slot cartridge enable
- busy  out  1  sequencer not in IDLE
- clr_err  out  1  sticky: a clear timed out; cleared on next sequence start

Behaviour:
- Async reset: state=HOLD, msx_reset=1, clr_req=0, clr_slot=0, slot_en=0, busy=1, clr_err=0, prev_typ[*]=EMPTY, rom_loaded=0, hold counter=0.
- The power-up sequence therefore treats both slots as changed.
- States: IDLE, HOLD, CLR_A, CLR_B, WAIT_DL, RELEASE.
- Sequence start means:
  - latch cart_typ into cur_typ;
  - compute chg[i] = cur_typ[i] != prev_typ[i];
  - clear rom_loaded[i] where chg[i];
  - zero the hold counter and clr_err;
  - go to HOLD.
- Sequence start happens on reload in any state, or on a download end (ioctl_download falling edge) with a ROM index while IDLE.
- reload has priority over every other transition, including clr_ack in the same cycle.
- Restarting from CLR_x drops clr_req the next cycle. clr_ack arriving while clr_req=0 is ignored.
- HOLD: count to HOLD_CYCLES-1. Then go to CLR_A if need[0], else CLR_B if need[1], else WAIT_DL.
  - need[i] = chg[i] AND cur_typ[i] not in {ROM, EMPTY}.
- CLR_x:
  - On entry, clr_req=1 and clr_slot=x; hold both stable until exit.
  - Exit on clr_ack, or on timeout counter = CLR_TIMEOUT-1 (then set clr_err).
  - clr_req=0 on the exit cycle's next edge.
  - CLR_A goes to CLR_B if need[1], else WAIT_DL.
  - CLR_B goes to WAIT_DL.
- WAIT_DL: stay while ioctl_download=1; else go to RELEASE.
- RELEASE, one cycle:
  - prev_typ <= cur_typ;
  - slot_en[i] <= cur_typ[i]!=EMPTY AND (cur_typ[i]!=ROM OR rom_loaded[i]);
  - msx_reset <= 0; next state IDLE.
- msx_reset=1 and busy=1 in every state except IDLE.
- slot_en is forced to 0 from sequence start until RELEASE.
- rom_loaded[i] is set on the ioctl_download falling edge when ioctl_index matches that slot's index, in any state.
  - The falling edge is detected with a registered copy of ioctl_download.
  - A falling edge outside IDLE sets the flag but does not restart the sequence.
- Download of any other index does not restart the sequence and does not touch the flags.
- Minimum reset pulse with no clears and no download: HOLD_CYCLES+2 cycles.

Decomposition:
- Shared package MSX, alongside the existing types:
  - cart_typ_t encoding: ROM=0, SCC=1, SCC+=2, FM-PAC=3, MFRSD=4, GM2=5, FDC=6, EMPTY=7;
  - new enum reload_state_t;
  - ROM index constants.
- One sub-module: msx_clr_timer, a loadable down-counter with expiry flag.
  - Used for both the HOLD count and the clear timeout.

Test Plan:
- Power-up, cart_typ={EMPTY,SCC}, HOLD_CYCLES=16 -> msx_reset high, one clr_req with clr_slot=0; ack after 5 cycles -> reset falls, slot_en=01, clr_err=0.
- Steady IDLE, reload with types {ROM,ROM}, no downloads -> no clr_req, msx_reset held 18 cycles, slot_en=00.
- Then ROM_A download (index 1) high 100 cycles and falling in IDLE -> restart, no clear; after release slot_en=01.
- Types {FM-PAC,SCC+} changed, clr_ack withheld, CLR_TIMEOUT=32 -> clr_req drops after 32 cycles, clr_err=1, slot B cleared next, final slot_en=11.
- reload asserted in same cycle as clr_ack during CLR_A -> sequence restarts in HOLD, clr_err cleared, CLR_A re-issued after hold.
- Download index 2 active while in HOLD and still high at WAIT_DL -> msx_reset stays high until falling edge+1, rom_loaded[1]=1, no extra restart.

Source files
------------

// File: rtl/msx_reload_seq_pkg.sv
// Shared MSX types for the cold-restart sequencer: cartridge type encoding,
// sequencer states and the default ROM download indices.
package msx_reload_seq_pkg;

  typedef enum logic [2:0] {
    CART_ROM   = 3'd0,
    CART_SCC   = 3'd1,
    CART_SCCP  = 3'd2,
    CART_FMPAC = 3'd3,
    CART_MFRSD = 3'd4,
    CART_GM2   = 3'd5,
    CART_FDC   = 3'd6,
    CART_EMPTY = 3'd7
  } cart_typ_t;

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_HOLD,
    RS_CLR_A,
    RS_CLR_B,
    RS_WAIT_DL,
    RS_RELEASE
  } reload_state_t;

  localparam logic [7:0] ROM_A_INDEX_DEF = 8'd1;
  localparam logic [7:0] ROM_B_INDEX_DEF = 8'd2;
  localparam int         TMR_W           = 21;

  // Mapper/SRAM-backed types own an SDRAM region that must be wiped on retype.
  function automatic logic needs_clear(input cart_typ_t t);
    return (t != CART_ROM) && (t != CART_EMPTY);
  endfunction

endpackage

// File: rtl/msx_clr_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module msx_clr_timer #(
  parameter int             W         = 21,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= RESET_VAL;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/msx_reload_seq.sv
// MSX cold-restart sequencer: holds the core in reset, clears retyped slot
// regions, waits out ROM downloads, then releases and publishes slot enables.
module msx_reload_seq
  import msx_reload_seq_pkg::*;
#(
  parameter int         HOLD_CYCLES = 1024,
  parameter int         CLR_TIMEOUT = 1048576,
  parameter logic [7:0] ROM_A_INDEX = ROM_A_INDEX_DEF,
  parameter logic [7:0] ROM_B_INDEX = ROM_B_INDEX_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       reload,
  input  logic [5:0] cart_typ,
  input  logic       ioctl_download,
  input  logic [7:0] ioctl_index,
  output logic       clr_req,
  output logic       clr_slot,
  input  logic       clr_ack,
  output logic       msx_reset,
  output logic [1:0] slot_en,
  output logic       busy,
  output logic       clr_err
);

  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLR_LOAD  = TMR_W'(CLR_TIMEOUT - 1);

  reload_state_t    state, next_state;
  cart_typ_t        in_typ   [2];
  cart_typ_t        cur_typ  [2];
  cart_typ_t        prev_typ [2];
  logic [1:0]       chg, chg_now, need, rom_loaded, rom_next, rel_en, rom_hit;
  logic             init_q, dl_q, dl_fall, seq_start, latch;
  logic             in_clr, tmr_load, tmr_expired, clr_timeout;
  logic [TMR_W-1:0] tmr_val;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    in_typ[0] = cart_typ_t'(cart_typ[2:0]);
    in_typ[1] = cart_typ_t'(cart_typ[5:3]);
    dl_fall   = dl_q & ~ioctl_download;
    rom_hit   = {dl_fall && (ioctl_index == ROM_B_INDEX),
                 dl_fall && (ioctl_index == ROM_A_INDEX)};
    seq_start = reload || ((state == RS_IDLE) && (rom_hit != 2'b00));
    // Out of reset the first cycle latches the live types without restarting HOLD.
    latch     = seq_start || init_q;
    in_clr    = (state == RS_CLR_A) || (state == RS_CLR_B);
    for (int i = 0; i < 2; i++) begin
      chg_now[i] = (in_typ[i] != prev_typ[i]);
      need[i]    = chg[i] && needs_clear(cur_typ[i]);
      rel_en[i]  = (cur_typ[i] != CART_EMPTY) &&
                   ((cur_typ[i] != CART_ROM) || rom_loaded[i]);
    end
    rom_next = rom_loaded;
    if (latch)
      rom_next = rom_next & ~chg_now;
    rom_next = rom_next | rom_hit;
    clr_timeout = in_clr && tmr_expired && !clr_ack && !reload;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= RS_HOLD;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (seq_start) begin
      next_state = RS_HOLD;
    end else begin
      case (state)
        RS_IDLE:    next_state = RS_IDLE;
        RS_HOLD:
          if (tmr_expired && !init_q)
            next_state = need[0] ? RS_CLR_A : (need[1] ? RS_CLR_B : RS_WAIT_DL);
        RS_CLR_A:
          if (clr_ack || tmr_expired)
            next_state = need[1] ? RS_CLR_B : RS_WAIT_DL;
        RS_CLR_B:
          if (clr_ack || tmr_expired)
            next_state = RS_WAIT_DL;
        RS_WAIT_DL:
          if (!ioctl_download)
            next_state = RS_RELEASE;
        RS_RELEASE: next_state = RS_IDLE;
        default:    next_state = RS_HOLD;
      endcase
    end
  end

  always_comb begin
    msx_reset = (state != RS_IDLE);
    busy      = (state != RS_IDLE);
    clr_req   = in_clr;
    clr_slot  = (state == RS_CLR_B);
  end

  // One timer serves both the hold count and the per-slot clear timeout.
  always_comb begin
    tmr_load = seq_start ||
               (((next_state == RS_CLR_A) || (next_state == RS_CLR_B)) &&
                (next_state != state));
    tmr_val  = seq_start ? HOLD_LOAD : CLR_LOAD;
  end

  msx_clr_timer #(
    .W         (TMR_W),
    .RESET_VAL (HOLD_LOAD)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q     <= 1'b1;
      dl_q       <= 1'b0;
      chg        <= 2'b00;
      rom_loaded <= 2'b00;
      slot_en    <= 2'b00;
      clr_err    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        cur_typ[i]  <= CART_EMPTY;
        prev_typ[i] <= CART_EMPTY;
      end
    end else begin
      init_q     <= 1'b0;
      dl_q       <= ioctl_download;
      rom_loaded <= rom_next;
      if (latch) begin
        chg     <= chg_now;
        slot_en <= 2'b00;
        clr_err <= 1'b0;
        for (int i = 0; i < 2; i++)
          cur_typ[i] <= in_typ[i];
      end else begin
        if (clr_timeout)
          clr_err <= 1'b1;
        if (state == RS_RELEASE) begin
          slot_en <= rel_en;
          for (int i = 0; i < 2; i++)
            prev_typ[i] <= cur_typ[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_msx_reload_seq.sv
// Scoreboard bench for msx_reload_seq: stimulus queues expected releases and
// clear requests, a negedge monitor pops and compares them as they appear.
module tb_msx_reload_seq;

  localparam int HOLD = 16;
  localparam int TOUT = 32;

  typedef struct {
    logic [1:0] slot_en;
    logic       err;
    int         len;
  } rel_exp_t;

  typedef struct {
    logic slot;
    int   len;
  } clr_exp_t;

  logic       clk = 1'b0;
  logic       reset_n, reload, ioctl_download, clr_ack;
  logic [5:0] cart_typ;
  logic [7:0] ioctl_index;
  logic       clr_req, clr_slot, msx_reset, busy, clr_err;
  logic [1:0] slot_en;

  rel_exp_t rel_q[$];
  clr_exp_t clr_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  msx_reload_seq #(
    .HOLD_CYCLES (HOLD),
    .CLR_TIMEOUT (TOUT),
    .ROM_A_INDEX (8'd1),
    .ROM_B_INDEX (8'd2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .reload         (reload),
    .cart_typ       (cart_typ),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .clr_req        (clr_req),
    .clr_slot       (clr_slot),
    .clr_ack        (clr_ack),
    .msx_reset      (msx_reset),
    .slot_en        (slot_en),
    .busy           (busy),
    .clr_err        (clr_err)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: segments msx_reset pulses and clear requests, compares on completion.
  logic prev_rst = 1'b1;
  int   rst_len  = 0;
  logic clr_act  = 1'b0;
  logic clr_cur  = 1'b0;
  int   clr_len  = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (msx_reset) begin
        rst_len++;
      end else if (prev_rst) begin
        if (rel_q.size() == 0) begin
          check("release_unexpected", rel_q.size(), 1);
        end else begin
          rel_exp_t e;
          e = rel_q.pop_front();
          check("slot_en", slot_en, e.slot_en);
          check("clr_err", clr_err, e.err);
          if (e.len != 0) check("reset_len", rst_len, e.len);
        end
        rst_len = 0;
      end
      prev_rst = msx_reset;

      if (clr_act && (!clr_req || clr_slot != clr_cur)) begin
        if (clr_q.size() == 0) begin
          check("clear_unexpected", clr_q.size(), 1);
        end else begin
          clr_exp_t c;
          c = clr_q.pop_front();
          check("clr_slot", clr_cur, c.slot);
          check("clr_len", clr_len, c.len);
        end
        clr_act = 1'b0;
      end
      if (clr_req && !clr_act) begin
        clr_act = 1'b1;
        clr_cur = clr_slot;
        clr_len = 0;
      end
      if (clr_act) clr_len++;
    end
  end

  task automatic pulse_reload();
    @(negedge clk) reload = 1'b1;
    @(negedge clk) reload = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || msx_reset) && n < budget);
    check("idle_reached", busy, 0);
  endtask

  task automatic wait_clr(input logic slot, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(clr_req && clr_slot == slot) && n < budget);
    check("clr_seen", clr_req && (clr_slot == slot), 1);
  endtask

  task automatic ack_after(input logic slot, input int n);
    wait_clr(slot, 300);
    repeat (n - 1) @(negedge clk);
    clr_ack = 1'b1;
    @(negedge clk) clr_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    reload         = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    clr_ack        = 1'b0;
    cart_typ       = {3'd7, 3'd1};          // B=EMPTY, A=SCC
    repeat (3) @(negedge clk);
    check("rst_msx_reset", msx_reset, 1);
    check("rst_busy", busy, 1);
    check("rst_clr_req", clr_req, 0);
    check("rst_clr_slot", clr_slot, 0);
    check("rst_slot_en", slot_en, 0);
    check("rst_clr_err", clr_err, 0);

    // Power-up: slot A retyped to SCC, one clear acked after 5 cycles.
    clr_q.push_back('{slot: 1'b0, len: 5});
    rel_q.push_back('{slot_en: 2'b01, err: 1'b0, len: 0});
    reset_n = 1'b1;
    ack_after(1'b0, 5);
    wait_idle(300);

    // Reload to {ROM,ROM}: no clears, minimum reset pulse, nothing loaded yet.
    cart_typ = {3'd0, 3'd0};
    rel_q.push_back('{slot_en: 2'b00, err: 1'b0, len: HOLD + 2});
    pulse_reload();
    wait_idle(300);

    // Slot A ROM download ends in IDLE: restart and enable slot A.
    rel_q.push_back('{slot_en: 2'b01, err: 1'b0, len: HOLD + 2});
    @(negedge clk);
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    repeat (100) @(negedge clk);
    ioctl_download = 1'b0;
    wait_idle(300);

    // Download of an unrelated index: no restart, enables untouched.
    @(negedge clk);
    ioctl_index    = 8'd5;
    ioctl_download = 1'b1;
    repeat (10) @(negedge clk);
    ioctl_download = 1'b0;
    repeat (5) @(negedge clk);
    check("other_idx_busy", busy, 0);
    check("other_idx_reset", msx_reset, 0);
    check("other_idx_slot_en", slot_en, 2'b01);

    // {FM-PAC,SCC+}: slot A clear times out, slot B acked after 3.
    cart_typ = {3'd3, 3'd2};
    clr_q.push_back('{slot: 1'b0, len: TOUT});
    clr_q.push_back('{slot: 1'b1, len: 3});
    rel_q.push_back('{slot_en: 2'b11, err: 1'b1, len: HOLD + TOUT + 3 + 2});
    pulse_reload();
    ack_after(1'b1, 3);
    wait_idle(300);

    // Slot A -> MFRSD; reload coincides with clr_ack during CLR_A.
    cart_typ = {3'd3, 3'd4};
    clr_q.push_back('{slot: 1'b0, len: 3});
    clr_q.push_back('{slot: 1'b0, len: 2});
    rel_q.push_back('{slot_en: 2'b11, err: 1'b0, len: HOLD + 3 + HOLD + 2 + 2});
    pulse_reload();
    wait_clr(1'b0, 300);
    repeat (2) @(negedge clk);
    reload  = 1'b1;
    clr_ack = 1'b1;
    @(negedge clk);
    reload  = 1'b0;
    clr_ack = 1'b0;
    check("restart_clr_req", clr_req, 0);
    check("restart_busy", busy, 1);
    check("restart_clr_err", clr_err, 0);
    ack_after(1'b0, 2);
    wait_idle(300);

    // Slot B -> ROM, its download spans HOLD and WAIT_DL; release after its end.
    cart_typ = {3'd0, 3'd4};
    rel_q.push_back('{slot_en: 2'b11, err: 1'b0, len: 46});
    pulse_reload();
    repeat (4) @(negedge clk);
    ioctl_index    = 8'd2;
    ioctl_download = 1'b1;
    repeat (40) @(negedge clk);
    ioctl_download = 1'b0;
    wait_idle(300);
    repeat (5) @(negedge clk);
    check("no_extra_restart", busy, 0);

    repeat (3) @(negedge clk);
    check("release_queue_left", rel_q.size(), 0);
    check("clear_queue_left", clr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
